// File: rtl/pow8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pow8_pkg
// Description : Shared defaults for the power_of_8_dw datapath and its
//               result buffer: data width, buffer depth, drop-counter width,
//               pointer width and the per-cycle FIFO operation encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pow8_pkg;

    // Defaults shared by power_of_8_dw and pow8_result_buffer
    localparam int c_DWIDTH = 32;
    localparam int c_DEPTH  = 4;
    localparam int c_DROP_W = 8;
    localparam int c_PTR_W  = $clog2(c_DEPTH);

    // Pointer width for a given depth; never narrower than one bit
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // What the FIFO does this cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage
`default_nettype wire

// File: rtl/pow8_buf_mem.sv
`default_nettype none
// ============================================================================
// Module      : pow8_buf_mem
// Description : DEPTH x DWIDTH register array with one synchronous write
//               port and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pow8_buf_mem
    import pow8_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH,
    parameter int DEPTH  = c_DEPTH,
    parameter int PTR_W  = ptr_width(c_DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_W-1:0]  i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]  i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] mem_d [DEPTH];

    // Next array contents: only the addressed entry changes on a write
    always_comb begin
        mem_d = mem_q;
        if (i_we) begin
            mem_d[i_waddr] = i_wdata;
        end
    end

    // Storage carries no reset; the control logic masks stale contents
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Asynchronous read of the head entry
    assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/pow8_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pow8_result_buffer
// Description : First-word-fall-through FIFO that captures x^8 results from
//               power_of_8_dw. Results arriving while full are dropped and
//               counted (sticky overflow flag, saturating drop counter).
//               A synchronous clear flushes the FIFO and the statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pow8_result_buffer
    import pow8_pkg::*;
#(
    parameter int DWIDTH = c_DWIDTH,
    parameter int DEPTH  = c_DEPTH,
    parameter int DROP_W = c_DROP_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_clr,
    input  logic                   i_valid,
    input  logic [DWIDTH-1:0]      i_value,
    output logic                   o_valid,
    output logic [DWIDTH-1:0]      o_data,
    input  logic                   i_ready,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_overflow,
    output logic [DROP_W-1:0]      o_drop_cnt
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0]  c_FULL_CNT = CNT_W'(DEPTH);
    localparam logic [DROP_W-1:0] c_DROP_MAX = '1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              w_not_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_mem_we;
    fifo_op_e          w_op;
    logic [DWIDTH-1:0] w_rdata;

    // Handshake decode; a pop frees a slot for a same-cycle push even when full
    always_comb begin
        w_not_empty = (count_q != '0);
        w_full      = (count_q == c_FULL_CNT);
        w_pop       = w_not_empty && i_ready;
        w_push      = i_valid && (!w_full || w_pop);
        w_drop      = i_valid && w_full && !w_pop;
        w_mem_we    = w_push && !i_clr;
        w_op        = fifo_op_e'({w_push, w_pop});
    end

    // Next-state for pointers, occupancy and drop statistics; clear wins
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (i_clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case (w_op)
                OP_PUSH: count_d = count_q + 1'b1;
                OP_POP:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (w_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != c_DROP_MAX) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    pow8_buf_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (wr_ptr_q),
        .i_wdata (i_value),
        .i_raddr (rd_ptr_q),
        .o_rdata (w_rdata)
    );

    // Outputs depend only on registered state; data reads zero when empty
    assign o_valid    = w_not_empty;
    assign o_data     = w_not_empty ? w_rdata : '0;
    assign o_count    = count_q;
    assign o_full     = w_full;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pow8_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pow8_result_buffer
// Description : Scoreboard bench for pow8_result_buffer (DEPTH=4, DROP_W=2).
//               A queue-based reference model predicts FIFO contents and
//               statistics; popped values go to a scoreboard queue that a
//               negedge monitor drains as the DUT hands entries downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pow8_result_buffer;

    localparam int DWIDTH   = 32;
    localparam int DEPTH    = 4;
    localparam int DROP_W   = 2;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              i_clr   = 1'b0;
    logic              i_valid = 1'b0;
    logic [DWIDTH-1:0] i_value = '0;
    logic              i_ready = 1'b0;
    logic              o_valid;
    logic [DWIDTH-1:0] o_data;
    logic [CNT_W-1:0]  o_count;
    logic              o_full;
    logic              o_overflow;
    logic [DROP_W-1:0] o_drop_cnt;

    pow8_result_buffer #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clr      (i_clr),
        .i_valid    (i_valid),
        .i_value    (i_value),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready),
        .o_count    (o_count),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_drop_cnt (o_drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO contents and drop statistics
    logic [DWIDTH-1:0] model_q[$];
    int                m_overflow = 0;
    int                m_drops    = 0;

    // Scoreboard: values the DUT must hand out, in order
    logic [DWIDTH-1:0] exp_q[$];

    // Expected visible state between edges
    int                exp_count    = 0;
    int                exp_overflow = 0;
    int                exp_drops    = 0;
    logic [DWIDTH-1:0] exp_head     = '0;
    bit                mon_en       = 1'b0;

    function automatic logic [DWIDTH-1:0] p8(input int unsigned x);
        logic [DWIDTH-1:0] r = 1;
        for (int k = 0; k < 8; k++) r = r * x;
        return r;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void snapshot();
        exp_count    = model_q.size();
        exp_overflow = m_overflow;
        exp_drops    = m_drops;
        exp_head     = (model_q.size() > 0) ? model_q[0] : '0;
    endfunction

    // Drive one cycle of stimulus and advance the model to the next edge
    task automatic cycle(input bit v, input logic [DWIDTH-1:0] val, input bit rdy, input bit clr);
        bit pop;
        bit push;
        snapshot();
        i_valid = v;
        i_value = val;
        i_ready = rdy;
        i_clr   = clr;
        if (clr) begin
            model_q.delete();
            m_overflow = 0;
            m_drops    = 0;
        end else begin
            pop  = (model_q.size() > 0) && rdy;
            push = v && ((model_q.size() < DEPTH) || pop);
            if (pop) exp_q.push_back(model_q.pop_front());
            if (push) model_q.push_back(val);
            else if (v) begin
                m_overflow = 1;
                if (m_drops < DROP_MAX) m_drops++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset between edges; outputs must clear before the next rising edge
    task automatic async_reset();
        mon_en  = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_clr   = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_o_count", o_count, 0);
        check("arst_o_full", o_full, 0);
        check("arst_o_overflow", o_overflow, 0);
        check("arst_o_drop_cnt", o_drop_cnt, 0);
        check("arst_o_data", o_data, 0);
        #1 reset_n = 1'b1;
        model_q.delete();
        exp_q.delete();
        m_overflow = 0;
        m_drops    = 0;
        snapshot();
        mon_en = 1'b1;
    endtask

    // Monitor: compare visible state and consume scoreboard entries on pops
    always @(negedge clk) begin
        if (mon_en) begin
            check("o_count", o_count, exp_count);
            check("o_valid", o_valid, (exp_count != 0));
            check("o_full", o_full, (exp_count == DEPTH));
            check("o_overflow", o_overflow, exp_overflow);
            check("o_drop_cnt", o_drop_cnt, exp_drops);
            if (o_valid && i_ready && !i_clr) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected: got o_data %0d expected no pop (t=%0t)", o_data, $time);
                end else begin
                    check("o_data_pop", o_data, exp_q.pop_front());
                end
            end else begin
                check("o_data_head", o_data, exp_head);
            end
        end
    end

    initial begin
        #1;
        check("rst_o_valid", o_valid, 0);
        check("rst_o_count", o_count, 0);
        check("rst_o_full", o_full, 0);
        check("rst_o_overflow", o_overflow, 0);
        check("rst_o_drop_cnt", o_drop_cnt, 0);
        check("rst_o_data", o_data, 0);
        #1 reset_n = 1'b1;
        mon_en = 1'b1;

        // Fill with 2^8, 3^8, 4^8 while stalled, then drain
        cycle(1, p8(2), 0, 0);
        cycle(1, p8(3), 0, 0);
        cycle(1, p8(4), 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);

        // Overflow: six pushes into four slots
        for (int i = 0; i < 6; i++) cycle(1, p8(i + 1), 0, 0);
        cycle(0, '0, 0, 0);

        // Full with simultaneous push and pop, then drain
        for (int i = 0; i < 3; i++) cycle(1, p8(10 + i), 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
        cycle(0, '0, 0, 1);

        // Streaming across the pointer wrap
        for (int i = 0; i < 10; i++) cycle(1, p8(i), 1, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 1, 0);

        // Drop counter saturation, then clear with a concurrent push
        for (int i = 0; i < 4; i++) cycle(1, p8(20 + i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, p8(30 + i), 0, 0);
        cycle(0, '0, 0, 0);
        cycle(1, p8(40), 1, 1);
        cycle(0, '0, 0, 0);

        // Asynchronous reset with three entries stored
        for (int i = 0; i < 3; i++) cycle(1, p8(50 + i), 0, 0);
        cycle(0, '0, 0, 0);
        async_reset();
        cycle(1, p8(7), 0, 0);
        cycle(0, '0, 0, 0);
        cycle(0, '0, 1, 0);
        cycle(0, '0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(bit'($urandom_range(0, 3) != 0),
                  p8($urandom_range(0, 300)),
                  bit'($urandom_range(0, 2) == 0),
                  bit'($urandom_range(0, 49) == 0));
        end

        // Drain whatever is left
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, '0, 1, 0);
        check("scoreboard_leftover", exp_q.size(), 0);
        check("model_empty_o_count", o_count, model_q.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
